// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and helpers for the crossbar output-side arbiters.
package cross_bar_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // Modulo-n increment, used to advance the round-robin pointer past a grant.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// Bundle of the N source streams plus the merged output stream of one
// crossbar output. master = arbiter view (drives merged stream and source
// readies), slave = environment view (sources and downstream sink).
interface axis_packet_arbiter_if #(
  parameter int S_SEL_WIDTH  = 3,
  parameter int S_CHANNEL_NO = 2**S_SEL_WIDTH,
  parameter int DATA_WIDTH   = 32
);
  logic [S_CHANNEL_NO-1:0][DATA_WIDTH-1:0] s_axis_tdata;
  logic [S_CHANNEL_NO-1:0]                 s_axis_tvalid;
  logic [S_CHANNEL_NO-1:0]                 s_axis_tlast;
  logic [S_CHANNEL_NO-1:0]                 s_axis_tready;
  logic [DATA_WIDTH-1:0]                   m_axis_tdata;
  logic                                    m_axis_tvalid;
  logic                                    m_axis_tlast;
  logic [S_SEL_WIDTH-1:0]                  m_axis_tid;
  logic                                    m_axis_tready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );
endinterface

// File: rtl/axis_packet_arbiter_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo N.
module round_robin_picker
  import cross_bar_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int N     = 2**SEL_W
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Scan N positions starting at rr_ptr; the first hit wins.
  always_comb begin
    int j;
    logic [SEL_W-1:0] jj;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N) j = j - N;
      jj = SEL_W'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin merge of N AXI-Stream sources into one
// registered AXI-Stream master. A grant is held from first beat to tlast.
module axis_packet_arbiter
  import cross_bar_pkg::*;
#(
  parameter int S_SEL_WIDTH  = 3,
  parameter int S_CHANNEL_NO = 2**S_SEL_WIDTH,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_packet_arbiter_if.master bus
);

  arb_state_t             state_q, state_d;
  logic [S_SEL_WIDTH-1:0] grant_q, grant_d;
  logic [S_SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [S_SEL_WIDTH-1:0] pick_idx;
  logic                   pick_found;
  logic                   out_free;
  logic                   accept;

  logic [DATA_WIDTH-1:0]  tdata_q;
  logic                   tvalid_q;
  logic                   tlast_q;
  logic [S_SEL_WIDTH-1:0] tid_q;

  round_robin_picker #(.SEL_W(S_SEL_WIDTH), .N(S_CHANNEL_NO)) u_picker (
    .req    (bus.s_axis_tvalid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Output slot can take a beat if empty or draining this cycle.
  assign out_free = !tvalid_q || bus.m_axis_tready;

  // Arbitration state, grant and round-robin pointer.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state, source readies and beat acceptance.
  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    rr_ptr_d          = rr_ptr_q;
    accept            = 1'b0;
    bus.s_axis_tready = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        bus.s_axis_tready[grant_q] = out_free;
        accept = bus.s_axis_tvalid[grant_q] && out_free;
        // Lock is only released by tlast; a stalled source holds it.
        if (accept && bus.s_axis_tlast[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = S_SEL_WIDTH'(rr_next(32'(grant_q), 32'(S_CHANNEL_NO)));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered output stage: load on accept, clear valid on drain.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tid_q    <= '0;
    end else if (accept) begin
      tvalid_q <= 1'b1;
      tlast_q  <= bus.s_axis_tlast[grant_q];
      tdata_q  <= bus.s_axis_tdata[grant_q];
      tid_q    <= grant_q;
    end else if (bus.m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tid    = tid_q;

endmodule
